uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 147 ++++++++++++++
 tb/tb_uart_rx_framer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling, one-byte output
// buffer with valid/ready handshake, and one-cycle framing-error / overrun strobes.
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

    // IDLE wait falling edge | START mid-start check | DATA 8 bits | STOP stop check | WAIT_HIGH break recovery
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_ovr;
    logic            w_rx_s;
    logic            w_half_tc;
    logic            w_full_tc;
    logic            w_sample;
    logic            w_deliver;
    logic            w_ferr;

    assign w_rx_s    = r_sync2;
    assign w_half_tc = (r_cnt == HALF_TC);
    assign w_full_tc = (r_cnt == FULL_TC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!rx_en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (!w_rx_s) w_next = START;
                START:     if (w_half_tc) w_next = w_rx_s ? IDLE : DATA;
                DATA:      if (w_full_tc && (r_idx == 3'd7)) w_next = STOP;
                STOP:      if (w_full_tc) w_next = w_rx_s ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (w_rx_s) w_next = IDLE;
                default:   w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_sample  = 1'b0;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        if (rx_en) begin
            case (r_state)
                DATA: w_sample = w_full_tc;
                STOP: begin
                    w_deliver = w_full_tc && w_rx_s;
                    w_ferr    = w_full_tc && !w_rx_s;
                end
                default: ;
            endcase
        end
    end

    // Counter restarts on every state change and after each data sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if ((w_next != r_state) || (r_state == IDLE) || (r_state == WAIT_HIGH) || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == START) && (w_next == DATA)) begin
                r_idx <= 3'd0;
            end else if (w_sample) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_sample) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || out_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: a fast instance driven by directed and random frames
// through a scoreboard, plus a full-rate instance for reset, latency and glitch behaviour.
module tb_uart_rx_framer;
    localparam int FC = 32;
    localparam int FH = FC / 2;
    localparam int SC = 868;
    localparam int SH = SC / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n = 1'b0, rx_en = 1'b1, rx = 1'b1, out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overrun;

    logic       s_rst_n = 1'b0, s_rx_en = 1'b1, s_rx = 1'b1, s_out_ready = 1'b0;
    logic [7:0] s_out_data;
    logic       s_out_valid, s_frame_err, s_overrun;

    uart_rx_framer #(.CLKS_PER_BIT(FC)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx_framer #(.CLKS_PER_BIT(SC)) u_slow (
        .clk(clk), .rst_n(s_rst_n), .rx_en(s_rx_en), .rx(s_rx),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .frame_err(s_frame_err), .overrun(s_overrun)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int issued_ferr = 0, seen_ferr = 0;
    int issued_ovr  = 0, seen_ovr  = 0;
    bit rdy_rand = 1'b0;
    bit rdy_val  = 1'b0;

    int s_rise_cnt = 0, s_rise_cyc = 0, s_ferr_cnt = 0, s_ovr_cnt = 0;
    bit s_prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL byte: got %0h, expected no byte", out_data);
                    end else begin
                        check("byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                    end
                end
                if (frame_err) begin
                    check("frame_err expected", {31'h0, seen_ferr < issued_ferr}, 32'd1);
                    seen_ferr++;
                end
                if (overrun) begin
                    check("overrun expected", {31'h0, seen_ovr < issued_ovr}, 32'd1);
                    seen_ovr++;
                end
            end
            if (s_out_valid && !s_prev_valid) begin
                s_rise_cnt++;
                s_rise_cyc = cyc;
            end
            s_prev_valid = s_out_valid;
            if (s_frame_err) s_ferr_cnt++;
            if (s_overrun)   s_ovr_cnt++;
        end
    endtask

    // Sends start, 8 data bits LSB first and the stop level; abort_idx drops rx_en at that frame bit.
    task automatic fsend(input logic [7:0] b, input bit good, input int extra_low, input int abort_idx);
        logic [9:0] frm;
        frm = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == abort_idx) rx_en = 1'b0;
            rx = frm[i];
            hold(FC);
        end
        if (!good && (extra_low > 0)) begin
            rx = 1'b0;
            hold(extra_low * FC);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 3000)) begin
            hold(1);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic slow_seq();
        logic [9:0] frm;
        int t0;
        hold(5);
        check("slow rst out_data",  {24'h0, s_out_data}, 32'h0);
        check("slow rst out_valid", {31'h0, s_out_valid}, 32'h0);
        check("slow rst frame_err", {31'h0, s_frame_err}, 32'h0);
        check("slow rst overrun",   {31'h0, s_overrun}, 32'h0);
        s_rst_n = 1'b1;
        hold(10);
        frm = {1'b1, 8'hEB, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            s_rx = frm[i];
            hold(SC);
        end
        check("slow valid rises once", s_rise_cnt, 32'd1);
        check("slow latency in 8248..8252",
              {31'h0, ((s_rise_cyc - t0) >= 8248) && ((s_rise_cyc - t0) <= 8252)}, 32'd1);
        check("slow data EB", {24'h0, s_out_data}, 32'hEB);
        hold(20);
        check("slow valid held", {31'h0, s_out_valid}, 32'd1);
        check("slow data held", {24'h0, s_out_data}, 32'hEB);
        s_out_ready = 1'b1;
        hold(1);
        s_out_ready = 1'b0;
        check("slow valid clears", {31'h0, s_out_valid}, 32'd0);
        s_rx = 1'b0;
        hold(200);
        s_rx = 1'b1;
        hold(1500);
        check("slow glitch no valid", s_rise_cnt, 32'd1);
        check("slow no frame_err", s_ferr_cnt, 32'd0);
        check("slow no overrun", s_ovr_cnt, 32'd0);
    endtask

    task automatic fast_seq();
        int tgt, kind, el;
        logic [7:0] b;
        hold(5);
        check("rst out_data",  {24'h0, out_data}, 32'h0);
        check("rst out_valid", {31'h0, out_valid}, 32'h0);
        check("rst frame_err", {31'h0, frame_err}, 32'h0);
        check("rst overrun",   {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        rdy_rand = 1'b1;
        hold(10);

        issued_ferr++;
        fsend(8'h55, 1'b0, 3, -1);
        rx = 1'b1;
        hold(FC);
        exp_q.push_back(8'hA3);
        fsend(8'hA3, 1'b1, 0, -1);
        rx = 1'b1;
        hold(FC);
        wait_drain();

        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        hold(4);
        exp_q.push_back(8'hF3);
        fsend(8'hF3, 1'b1, 0, -1);
        issued_ovr++;
        fsend(8'h0C, 1'b1, 0, -1);
        hold(FC);
        rdy_val = 1'b1;
        hold(4);
        rdy_val = 1'b0;
        hold(4);
        check("overrun seen once", seen_ovr, 32'd1);
        check("F3 kept and taken", exp_q.size(), 32'd0);

        exp_q.push_back(8'hF3);
        fsend(8'hF3, 1'b1, 0, -1);
        exp_q.push_back(8'h0C);
        tgt = cyc + 2 + FH + 9 * FC;
        fork
            fsend(8'h0C, 1'b1, 0, -1);
            begin
                while (cyc < tgt) hold(1);
                rdy_val = 1'b1;
                hold(1);
                rdy_val = 1'b0;
            end
        join
        hold(FC);
        check("0C pending after same-cycle take", exp_q.size(), 32'd1);
        rdy_rand = 1'b1;
        wait_drain();

        exp_q.push_back(8'h81);
        fsend(8'h3C, 1'b1, 0, 5);
        rx = 1'b1;
        hold(FC);
        rx_en = 1'b1;
        hold(FC);
        fsend(8'h81, 1'b1, 0, -1);
        rx = 1'b1;
        hold(FC);
        wait_drain();

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            b = 8'($urandom);
            if (kind < 7) begin
                exp_q.push_back(b);
                fsend(b, 1'b1, 0, -1);
            end else if (kind < 9) begin
                el = $urandom_range(0, 3);
                issued_ferr++;
                fsend(b, 1'b0, el, -1);
            end else begin
                rx = 1'b0;
                hold($urandom_range(1, FH - 4));
            end
            rx = 1'b1;
            hold($urandom_range(FC, 2 * FC));
        end
        wait_drain();
        hold(10);
        check("frame_err count", seen_ferr, issued_ferr);
        check("overrun count", seen_ovr, issued_ovr);
    endtask

    initial begin
        hold(0);
        fork
            monitor_loop();
            ready_driver();
        join_none
        fork
            slow_seq();
            fast_seq();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL timeout: simulation exceeded 90000 cycles");
        $fatal(1);
    end

endmodule
